keypad_entry_controller: RTL

- Sequences multi-digit code entry from the 12-key keypad driver: consumes its one-cycle key_value/key_valid pulses and builds a BCD digit buffer.
- '*' is backspace and '#' is submit.
- Presents completed entries to the game FSM with a valid/ack handshake.
- Provides a live buffer for the 7-segment display and clears stale entries on an inactivity timeout.

---
 rtl/keypad_entry_controller.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/keypad_entry_controller.sv
// Keypad code-entry sequencer: builds a BCD digit buffer from key strobes,
// presents submitted entries with a valid/ack handshake and clears stale input on timeout.
module keypad_entry_controller #(
  parameter int MAX_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 250000000,
  parameter int TO_W           = 28
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [3:0]              key_value,
  input  logic                    key_valid,
  input  logic                    entry_ack,
  output logic                    entry_valid,
  output logic [4*MAX_DIGITS-1:0] entry_bcd,
  output logic [2:0]              entry_len,
  output logic [4*MAX_DIGITS-1:0] disp_bcd,
  output logic [2:0]              disp_len,
  output logic                    reject_pulse,
  output logic                    timeout_pulse
);

  localparam int              BW       = 4 * MAX_DIGITS;
  localparam logic [2:0]      MAX_LEN  = 3'(MAX_DIGITS);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      KEY_STAR = 4'd10;
  localparam logic [3:0]      KEY_HASH = 4'd11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTRY   = 2'd1,
    PENDING = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [BW-1:0]   digits_next, entry_bcd_next, shifted_in;
  logic [2:0]      len_next, entry_len_next;
  logic            entry_valid_next, reject_next, timeout_next;
  logic [TO_W-1:0] timer, timer_next;
  logic            accepted, is_digit;

  assign accepted = key_valid & enable;
  assign is_digit = (key_value <= 4'd9);

  // New digit enters the least significant nibble; older digits move up.
  always_comb begin
    shifted_in      = disp_bcd << 4;
    shifted_in[3:0] = key_value;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      disp_bcd      <= '0;
      disp_len      <= '0;
      entry_bcd     <= '0;
      entry_len     <= '0;
      entry_valid   <= 1'b0;
      reject_pulse  <= 1'b0;
      timeout_pulse <= 1'b0;
      timer         <= '0;
    end else begin
      state         <= state_next;
      disp_bcd      <= digits_next;
      disp_len      <= len_next;
      entry_bcd     <= entry_bcd_next;
      entry_len     <= entry_len_next;
      entry_valid   <= entry_valid_next;
      reject_pulse  <= reject_next;
      timeout_pulse <= timeout_next;
      timer         <= timer_next;
    end
  end

  always_comb begin
    state_next       = state;
    digits_next      = disp_bcd;
    len_next         = disp_len;
    entry_bcd_next   = entry_bcd;
    entry_len_next   = entry_len;
    entry_valid_next = entry_valid;
    reject_next      = 1'b0;
    timeout_next     = 1'b0;
    timer_next       = '0;

    case (state)
      IDLE: begin
        if (accepted) begin
          if (is_digit) begin
            digits_next      = '0;
            digits_next[3:0] = key_value;
            len_next         = 3'd1;
            state_next       = ENTRY;
          end else if (key_value != KEY_STAR) begin
            reject_next = 1'b1;
          end
        end
      end

      ENTRY: begin
        // Losing enable abandons the entry quietly; a key beats a same-cycle timeout.
        if (!enable) begin
          digits_next = '0;
          len_next    = '0;
          state_next  = IDLE;
        end else if (key_valid) begin
          if (is_digit) begin
            if (disp_len < MAX_LEN) begin
              digits_next = shifted_in;
              len_next    = disp_len + 3'd1;
            end else begin
              reject_next = 1'b1;
            end
          end else if (key_value == KEY_STAR) begin
            digits_next = disp_bcd >> 4;
            len_next    = disp_len - 3'd1;
            if (disp_len == 3'd1) state_next = IDLE;
          end else if (key_value == KEY_HASH) begin
            entry_bcd_next   = disp_bcd;
            entry_len_next   = disp_len;
            entry_valid_next = 1'b1;
            digits_next      = '0;
            len_next         = '0;
            state_next       = PENDING;
          end else begin
            reject_next = 1'b1;
          end
        end else if (timer == TO_LAST) begin
          digits_next  = '0;
          len_next     = '0;
          timeout_next = 1'b1;
          state_next   = IDLE;
        end else begin
          timer_next = timer + TO_W'(1);
        end
      end

      PENDING: begin
        // Ack takes priority; a key arriving with it is dropped without complaint.
        if (entry_ack) begin
          entry_valid_next = 1'b0;
          state_next       = IDLE;
        end else if (accepted) begin
          reject_next = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule
